// File: rtl/cam_ctrl_pkg.sv
// Shared types for the CAM sequencing controller: FSM states, op type, insert status codes.
package cam_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEARCH,
        WAIT,
        WRITE,
        FLUSH
    } state_e;

    typedef enum logic {
        OP_LOOKUP,
        OP_INSERT
    } op_e;

    localparam logic [1:0] ST_INSERTED = 2'b00;
    localparam logic [1:0] ST_PRESENT  = 2'b01;
    localparam logic [1:0] ST_FULL     = 2'b10;

endpackage

// File: rtl/cam_rr_arb.sv
// Two-requester round-robin arbiter; the pointer only moves when both sides contend while enabled.
module cam_rr_arb (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic req_a_i,
    input  logic req_b_i,
    output logic gnt_a_o,
    output logic gnt_b_o
);

    logic ptr_q, ptr_d;   // 0 favours requester a

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        gnt_a_o = 1'b0;
        gnt_b_o = 1'b0;
        ptr_d   = ptr_q;
        if (en_i) begin
            if (req_a_i && req_b_i) begin
                gnt_a_o = !ptr_q;
                gnt_b_o = ptr_q;
                ptr_d   = !ptr_q;
            end else begin
                gnt_a_o = req_a_i;
                gnt_b_o = req_b_i;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= 1'b0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/cam_ctrl.sv
// Sequencing controller in front of the CAM: arbitrates lookup/insert, runs search-then-write, owns the CAM clear.
module cam_ctrl
    import cam_ctrl_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lk_valid,
    output logic              lk_ready,
    input  logic [DATA_W-1:0] lk_key,
    output logic              lk_rsp_valid,
    output logic              lk_rsp_hit,
    output logic [ADDR_W-1:0] lk_rsp_addr,
    input  logic              ins_valid,
    output logic              ins_ready,
    input  logic [DATA_W-1:0] ins_key,
    output logic              ins_rsp_valid,
    output logic [1:0]        ins_rsp_status,
    output logic [ADDR_W-1:0] ins_rsp_addr,
    input  logic              flush,
    output logic [ADDR_W:0]   occupancy,
    output logic              cam_enable,
    output logic              cam_write,
    output logic              cam_rst_n,
    output logic [ADDR_W-1:0] cam_addr,
    output logic [DATA_W-1:0] cam_data,
    input  logic [ADDR_W-1:0] cam_out,
    input  logic              cam_found
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic              flush_pend_q, flush_pend_d;
    logic [ADDR_W:0]   occ_q, occ_d;
    logic [DATA_W-1:0] cam_data_q, cam_data_d;
    logic [ADDR_W-1:0] cam_addr_q, cam_addr_d;
    logic              cam_enable_q, cam_write_q, cam_rst_n_q;
    logic              lk_rsp_valid_q, lk_rsp_valid_d;
    logic              lk_rsp_hit_q, lk_rsp_hit_d;
    logic [ADDR_W-1:0] lk_rsp_addr_q, lk_rsp_addr_d;
    logic              ins_rsp_valid_q, ins_rsp_valid_d;
    logic [1:0]        ins_status_q, ins_status_d;
    logic [ADDR_W-1:0] ins_rsp_addr_q, ins_rsp_addr_d;

    logic flush_req, arb_en, gnt_lk, gnt_ins;

    // A flush pulse seen in IDLE wins immediately, without waiting for the pending bit.
    assign flush_req = flush_pend_q | flush;
    assign arb_en    = (state_q == IDLE) && !flush_req;

    cam_rr_arb u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (arb_en),
        .req_a_i (lk_valid),
        .req_b_i (ins_valid),
        .gnt_a_o (gnt_lk),
        .gnt_b_o (gnt_ins)
    );

    assign lk_ready  = gnt_lk;
    assign ins_ready = gnt_ins;

    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        flush_pend_d    = flush_pend_q | flush;
        occ_d           = occ_q;
        cam_data_d      = cam_data_q;
        cam_addr_d      = cam_addr_q;
        lk_rsp_valid_d  = 1'b0;
        lk_rsp_hit_d    = lk_rsp_hit_q;
        lk_rsp_addr_d   = lk_rsp_addr_q;
        ins_rsp_valid_d = 1'b0;
        ins_status_d    = ins_status_q;
        ins_rsp_addr_d  = ins_rsp_addr_q;

        unique case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d = FLUSH;
                    occ_d   = '0;
                end else if (gnt_lk) begin
                    state_d    = SEARCH;
                    op_d       = OP_LOOKUP;
                    cam_data_d = lk_key;
                end else if (gnt_ins) begin
                    state_d    = SEARCH;
                    op_d       = OP_INSERT;
                    cam_data_d = ins_key;
                end
            end
            SEARCH: state_d = WAIT;
            WAIT: begin
                state_d = IDLE;
                if (op_q == OP_LOOKUP) begin
                    lk_rsp_valid_d = 1'b1;
                    lk_rsp_hit_d   = cam_found;
                    lk_rsp_addr_d  = cam_found ? cam_out : '0;
                end else if (cam_found) begin
                    ins_rsp_valid_d = 1'b1;
                    ins_status_d    = ST_PRESENT;
                    ins_rsp_addr_d  = cam_out;
                end else if (occ_q >= DEPTH_C) begin
                    ins_rsp_valid_d = 1'b1;
                    ins_status_d    = ST_FULL;
                    ins_rsp_addr_d  = '0;
                end else begin
                    state_d    = WRITE;
                    cam_addr_d = occ_q[ADDR_W-1:0];
                end
            end
            WRITE: begin
                state_d         = IDLE;
                ins_rsp_valid_d = 1'b1;
                ins_status_d    = ST_INSERTED;
                ins_rsp_addr_d  = cam_addr_q;
                if (occ_q < DEPTH_C) occ_d = occ_q + (ADDR_W+1)'(1);
            end
            FLUSH: begin
                state_d      = IDLE;
                flush_pend_d = flush;
            end
            default: state_d = IDLE;
        endcase
    end

    // CAM strobes are registered copies of the state being entered, so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            op_q            <= OP_LOOKUP;
            flush_pend_q    <= 1'b0;
            occ_q           <= '0;
            cam_data_q      <= '0;
            cam_addr_q      <= '0;
            cam_enable_q    <= 1'b0;
            cam_write_q     <= 1'b0;
            cam_rst_n_q     <= 1'b1;
            lk_rsp_valid_q  <= 1'b0;
            lk_rsp_hit_q    <= 1'b0;
            lk_rsp_addr_q   <= '0;
            ins_rsp_valid_q <= 1'b0;
            ins_status_q    <= ST_INSERTED;
            ins_rsp_addr_q  <= '0;
        end else begin
            state_q         <= state_d;
            op_q            <= op_d;
            flush_pend_q    <= flush_pend_d;
            occ_q           <= occ_d;
            cam_data_q      <= cam_data_d;
            cam_addr_q      <= cam_addr_d;
            cam_enable_q    <= (state_d == SEARCH);
            cam_write_q     <= (state_d == WRITE);
            cam_rst_n_q     <= (state_d != FLUSH);
            lk_rsp_valid_q  <= lk_rsp_valid_d;
            lk_rsp_hit_q    <= lk_rsp_hit_d;
            lk_rsp_addr_q   <= lk_rsp_addr_d;
            ins_rsp_valid_q <= ins_rsp_valid_d;
            ins_status_q    <= ins_status_d;
            ins_rsp_addr_q  <= ins_rsp_addr_d;
        end
    end

    assign occupancy      = occ_q;
    assign cam_enable     = cam_enable_q;
    assign cam_write      = cam_write_q;
    assign cam_rst_n      = cam_rst_n_q;
    assign cam_addr       = cam_addr_q;
    assign cam_data       = cam_data_q;
    assign lk_rsp_valid   = lk_rsp_valid_q;
    assign lk_rsp_hit     = lk_rsp_hit_q;
    assign lk_rsp_addr    = lk_rsp_addr_q;
    assign ins_rsp_valid  = ins_rsp_valid_q;
    assign ins_rsp_status = ins_status_q;
    assign ins_rsp_addr   = ins_rsp_addr_q;

endmodule

// File: tb/tb_cam_ctrl.sv
// Directed bench for cam_ctrl with a small behavioural 16-entry CAM attached to its CAM pins.
module tb_cam_ctrl;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 16;

    logic              clk, rst_n;
    logic              lk_valid, lk_ready, lk_rsp_valid, lk_rsp_hit;
    logic [DATA_W-1:0] lk_key;
    logic [ADDR_W-1:0] lk_rsp_addr;
    logic              ins_valid, ins_ready, ins_rsp_valid;
    logic [DATA_W-1:0] ins_key;
    logic [1:0]        ins_rsp_status;
    logic [ADDR_W-1:0] ins_rsp_addr;
    logic              flush;
    logic [ADDR_W:0]   occupancy;
    logic              cam_enable, cam_write, cam_rst_n;
    logic [ADDR_W-1:0] cam_addr, cam_out;
    logic [DATA_W-1:0] cam_data;
    logic              cam_found;

    int n_cmp = 0;
    int n_err = 0;
    int wr_pulses = 0;
    int overlap = 0;

    cam_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_key(lk_key),
        .lk_rsp_valid(lk_rsp_valid), .lk_rsp_hit(lk_rsp_hit), .lk_rsp_addr(lk_rsp_addr),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_key(ins_key),
        .ins_rsp_valid(ins_rsp_valid), .ins_rsp_status(ins_rsp_status), .ins_rsp_addr(ins_rsp_addr),
        .flush(flush), .occupancy(occupancy),
        .cam_enable(cam_enable), .cam_write(cam_write), .cam_rst_n(cam_rst_n),
        .cam_addr(cam_addr), .cam_data(cam_data), .cam_out(cam_out), .cam_found(cam_found)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural CAM: registered search result, lowest address wins on duplicates.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  vld;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0; cam_found <= 1'b0; cam_out <= '0;
        end else if (!cam_rst_n) begin
            vld <= '0; cam_found <= 1'b0; cam_out <= '0;
        end else begin
            if (cam_write) begin
                mem[cam_addr[3:0]] <= cam_data;
                vld[cam_addr[3:0]] <= 1'b1;
            end
            if (cam_enable) begin
                cam_found <= 1'b0;
                cam_out   <= '0;
                for (int i = DEPTH-1; i >= 0; i--) begin
                    if (vld[i] && mem[i] == cam_data) begin
                        cam_found <= 1'b1;
                        cam_out   <= ADDR_W'(i);
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        if (cam_write) wr_pulses++;
        if (cam_enable && cam_write) overlap++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one request, wait for its grant, and leave 1ns into cycle 1 with valid dropped.
    task automatic accept(input bit is_ins, input logic [7:0] key, output bit got);
        got = 1'b0;
        @(negedge clk);
        if (is_ins) begin ins_valid = 1'b1; ins_key = key; end
        else begin lk_valid = 1'b1; lk_key = key; end
        for (int n = 0; n < 20; n++) begin
            #1;
            if (is_ins ? ins_ready : lk_ready) begin got = 1'b1; break; end
            @(negedge clk);
        end
        if (!got) check("grant_timeout", 32'(got), 32'(1));
        else begin
            @(posedge clk);
            #1;
        end
        ins_valid = 1'b0;
        lk_valid  = 1'b0;
    endtask

    task automatic do_req(input bit is_ins, input logic [7:0] key, output int lat);
        bit got;
        lat = -1;
        accept(is_ins, key, got);
        if (got) begin
            for (int n = 1; n <= 10; n++) begin
                @(negedge clk);
                if (is_ins ? ins_rsp_valid : lk_rsp_valid) begin lat = n; break; end
            end
        end
    endtask

    initial begin
        int  lat, w0, strobes;
        bit  got;
        rst_n = 1'b0; lk_valid = 1'b0; ins_valid = 1'b0; flush = 1'b0;
        lk_key = '0; ins_key = '0;

        #12;
        check("rst_lk_rsp_valid", 32'(lk_rsp_valid), 0);
        check("rst_ins_rsp_valid", 32'(ins_rsp_valid), 0);
        check("rst_occupancy", 32'(occupancy), 0);
        check("rst_cam_rst_n", 32'(cam_rst_n), 1);
        check("rst_cam_en_wr", 32'({cam_enable, cam_write}), 0);
        check("rst_cam_addr_data", 32'({cam_addr, cam_data}), 0);
        @(negedge clk); rst_n = 1'b1;

        // Fill the table with 0x10..0x1F.
        for (int i = 0; i < DEPTH; i++) begin
            do_req(1'b1, 8'(8'h10 + i), lat);
            check($sformatf("fill%0d_lat", i), 32'(lat), 4);
            check($sformatf("fill%0d_status", i), 32'(ins_rsp_status), 32'(2'b00));
            check($sformatf("fill%0d_addr", i), 32'(ins_rsp_addr), 32'(i));
        end
        @(negedge clk);
        check("fill_occupancy", 32'(occupancy), 16);

        do_req(1'b0, 8'h1A, lat);
        check("lk1a_lat", 32'(lat), 3);
        check("lk1a_hit", 32'(lk_rsp_hit), 1);
        check("lk1a_addr", 32'(lk_rsp_addr), 10);
        do_req(1'b0, 8'h55, lat);
        check("lk55_lat", 32'(lat), 3);
        check("lk55_hit", 32'(lk_rsp_hit), 0);
        check("lk55_addr", 32'(lk_rsp_addr), 0);

        do_req(1'b1, 8'h13, lat);
        check("dup_lat", 32'(lat), 3);
        check("dup_status", 32'(ins_rsp_status), 32'(2'b01));
        check("dup_addr", 32'(ins_rsp_addr), 3);
        check("dup_occupancy", 32'(occupancy), 16);

        w0 = wr_pulses;
        do_req(1'b1, 8'hAA, lat);
        check("full_lat", 32'(lat), 3);
        check("full_status", 32'(ins_rsp_status), 32'(2'b10));
        check("full_addr", 32'(ins_rsp_addr), 0);
        repeat (2) @(negedge clk);
        check("full_no_write", 32'(wr_pulses - w0), 0);
        check("full_occupancy", 32'(occupancy), 16);

        // Both requesters held high: grants alternate starting with lookup.
        @(negedge clk);
        lk_valid = 1'b1; ins_valid = 1'b1; lk_key = 8'h11; ins_key = 8'h13;
        for (int g = 0; g < 4; g++) begin
            for (int n = 0; n < 20; n++) begin
                #1;
                if (lk_ready || ins_ready) break;
                @(negedge clk);
            end
            check($sformatf("rr%0d_granted", g), 32'(lk_ready ^ ins_ready), 1);
            check($sformatf("rr%0d_side_ins", g), 32'(ins_ready), 32'(g % 2));
            @(posedge clk);
            if (g < 3) @(negedge clk);
        end
        #1; lk_valid = 1'b0; ins_valid = 1'b0;
        repeat (6) @(negedge clk);

        // Flush an idle, full table.
        flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (!cam_rst_n) break;
        end
        check("flush1_cam_rst_n", 32'(cam_rst_n), 0);
        check("flush1_occupancy", 32'(occupancy), 0);
        @(negedge clk);
        check("flush1_release", 32'(cam_rst_n), 1);

        // Flush during an insert's SEARCH: insert completes, then the flush cycle.
        accept(1'b1, 8'h10, got);
        check("fsrch_in_search", 32'(cam_enable), 1);
        flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        lat = -1;
        for (int n = 2; n <= 10; n++) begin
            @(negedge clk);
            if (ins_rsp_valid) begin lat = n; break; end
        end
        check("fsrch_lat", 32'(lat), 4);
        check("fsrch_status", 32'(ins_rsp_status), 32'(2'b00));
        check("fsrch_addr", 32'(ins_rsp_addr), 0);
        check("fsrch_occ_before", 32'(occupancy), 1);
        check("fsrch_cam_rst_n_before", 32'(cam_rst_n), 1);
        @(negedge clk);
        check("fsrch_cam_rst_n", 32'(cam_rst_n), 0);
        check("fsrch_occupancy", 32'(occupancy), 0);
        @(negedge clk);
        check("fsrch_single_cycle", 32'(cam_rst_n), 1);
        do_req(1'b0, 8'h10, lat);
        check("post_flush_lat", 32'(lat), 3);
        check("post_flush_hit", 32'(lk_rsp_hit), 0);

        // Reset in the middle of WRITE.
        accept(1'b1, 8'h30, got);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (cam_write) break;
        end
        check("mid_wr_seen", 32'(cam_write), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cam_write", 32'(cam_write), 0);
        check("mid_rst_cam_enable", 32'(cam_enable), 0);
        check("mid_rst_cam_rst_n", 32'(cam_rst_n), 1);
        check("mid_rst_occupancy", 32'(occupancy), 0);
        check("mid_rst_cam_addr_data", 32'({cam_addr, cam_data}), 0);
        check("mid_rst_rsp", 32'({ins_rsp_valid, lk_rsp_valid, ins_rsp_status}), 0);
        strobes = 0;
        repeat (3) begin
            @(negedge clk);
            if (ins_rsp_valid || lk_rsp_valid) strobes++;
        end
        check("mid_rst_no_strobe", 32'(strobes), 0);
        rst_n = 1'b1;
        do_req(1'b1, 8'h20, lat);
        check("after_rst_lat", 32'(lat), 4);
        check("after_rst_status", 32'(ins_rsp_status), 32'(2'b00));
        check("after_rst_addr", 32'(ins_rsp_addr), 0);
        check("after_rst_occupancy", 32'(occupancy), 1);

        repeat (2) @(negedge clk);
        check("enable_write_overlap", 32'(overlap), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cam_ctrl.md
Name: cam_ctrl

Overview:
- Sequencing controller in front of the 16-entry, 8-bit-key `cam`.
- Arbitrates between a lookup requester and an insert requester, and turns each insert into search-then-write with sequential slot allocation.
- Reports a per-request result and owns the CAM's clear line.
- It is the only block that drives the CAM's enable, write, addr and data pins.

Parameters:
DATA_W, 8, key width; matches the cam data port
ADDR_W, 5, CAM address width; matches the cam addr/out ports
DEPTH, 16, number of usable CAM entries; DEPTH <= 2**ADDR_W

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
lk_valid  in  1  lookup request
lk_ready  out  1  lookup accepted when lk_valid & lk_ready
lk_key  in  DATA_W  lookup key
lk_rsp_valid  out  1  one-cycle lookup result strobe
lk_rsp_hit  out  1  key present
lk_rsp_addr  out  ADDR_W  matching address (lowest on duplicates); 0 on miss
ins_valid  in  1  insert request
ins_ready  out  1  insert accepted when ins_valid & ins_ready
ins_key  in  DATA_W  key to insert
ins_rsp_valid  out  1  one-cycle insert result strobe
ins_rsp_status  out  2  00 inserted, 01 already present, 10 table full
ins_rsp_addr  out  ADDR_W  slot written or slot found; 0 when full
flush  in  1  one-cycle pulse: clear table
occupancy  out  ADDR_W+1  entries allocated, 0..DEPTH
cam_enable  out  1  CAM search strobe
cam_write  out  1  CAM write strobe
cam_rst_n  out  1  CAM clear, active low
cam_addr  out  ADDR_W  CAM write address
cam_data  out  DATA_W  CAM key/data
cam_out  in  ADDR_W  CAM match address
cam_found  in  1  CAM match flag

Behaviour:
- Reset values:
  - All rsp_valid outputs, hit, status, rsp addrs, cam_enable, cam_write, cam_addr, cam_data, occupancy: 0.
  - cam_rst_n: 1.
  - FSM in IDLE; round-robin pointer favours lookup.
- All outputs are registered, except lk_ready and ins_ready, which are decoded from state.
- FSM states: IDLE, SEARCH, WAIT, WRITE, FLUSH.
  - Key and operation type are latched at acceptance.
- IDLE:
  - A pending flush has absolute priority: go to FLUSH, both readies 0.
  - Otherwise, if exactly one valid is high, grant it.
  - If both are high, grant the pointer side; the pointer then flips to the other side.
  - Only the granted requester sees ready=1. Both readies are 0 in every state other than IDLE.
- SEARCH: cam_enable=1, cam_data=key, cam_write=0. The CAM registers its result at the end of this cycle.
- WAIT: sample cam_found and cam_out.
  - Lookup: next cycle lk_rsp_valid=1 with hit=cam_found and addr=cam_out (0 if miss). Return to IDLE.
  - Insert, hit: next cycle status=01, addr=cam_out. Return to IDLE.
  - Insert, miss, occupancy==DEPTH: next cycle status=10, addr=0. Return to IDLE.
  - Insert, miss, occupancy<DEPTH: go to WRITE.
- WRITE: cam_write=1, cam_enable=0, cam_addr=occupancy[ADDR_W-1:0], cam_data=key.
  - Next cycle: status=00, addr=written slot, occupancy+1. Return to IDLE.
- Latency from the accept cycle (cycle 0):
  - Lookup response in cycle 3.
  - Insert hit or full response in cycle 3.
  - Insert success response in cycle 4.
  - Back-to-back requests: a new acceptance can occur in the response cycle.
- cam_enable and cam_write are never high in the same cycle.
- flush:
  - Latched into a pending bit in any state; an in-flight operation completes first.
  - FLUSH lasts one cycle: cam_rst_n=0, occupancy<=0, pending cleared. Return to IDLE.
  - A flush arriving during the FLUSH cycle re-arms pending and causes one more flush.
- rst_n asserted mid-operation: abort immediately to reset values with no response strobe. The CAM contents are cleared by the system reset.
- Occupancy saturates at DEPTH and never wraps. There is no delete; only flush frees entries.

Decomposition:
- Package cam_ctrl_pkg:
  - state enum (IDLE, SEARCH, WAIT, WRITE, FLUSH);
  - status constants ST_INSERTED=2'b00, ST_PRESENT=2'b01, ST_FULL=2'b10;
  - operation type enum (OP_LOOKUP, OP_INSERT).
- One sub-module, cam_rr_arb: 2-requester round-robin grant with a pointer register, enabled only in IDLE.

Test Plan:
- Insert keys 0x10..0x1F in order -> status 00, addr 0..15, occupancy 16; each response exactly 4 cycles after acceptance.
- Lookup 0x1A -> hit=1, addr=10, 3 cycles after acceptance. Lookup 0x55 -> hit=0, addr=0.
- Insert 0x13 again -> status 01, addr 3, occupancy unchanged. With the table full, insert 0xAA -> status 10, addr 0, no cam_write pulse.
- lk_valid and ins_valid held high together for 4 grants -> grants alternate lookup, insert, lookup, insert. Assert cam_enable & cam_write never both 1.
- flush pulsed during an insert's SEARCH -> insert completes with status 00; then one cycle with cam_rst_n=0 and occupancy=0. A following lookup of 0x10 -> hit=0.
- rst_n dropped during WRITE -> all outputs at reset values immediately, no rsp strobe. After release, insert 0x20 -> addr 0.
